qsys_shield_oc_guard_master: RTL and testbench

Avalon-MM master that services the shield over-current interrupt. It drives the control/status register of the shield module control slave to shut down a faulted module, waits a cooldown, then restores the module and checks whether the fault has cleared. After RETRY_MAX failed restores it latches a permanent fault until software clears it. It sits in the Qsys system alongside the control slave, so the MCU no longer has to service over-current in firmware.

---
 rtl/qsys_shield_oc_guard_master.sv | 111 +++++++++++
 tb/tb_qsys_shield_oc_guard_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_shield_oc_guard_master.sv
// qsys_shield_oc_guard_master: Avalon-MM master that sheds over-current shield modules,
// retries restores after a cooldown, and latches a permanent fault after RETRY_MAX failures.
module qsys_shield_oc_guard_master #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = '0,
  parameter int COOLDOWN_CYCLES = 50000000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int RETRY_MAX = 3
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  output logic [ADDR_W-1:0] avm_M_address,
  output logic              avm_M_read,
  output logic              avm_M_write,
  output logic [31:0]       avm_M_writedata,
  output logic [3:0]        avm_M_byteenable,
  input  logic [31:0]       avm_M_readdata,
  input  logic              avm_M_waitrequest,
  input  logic              inr_OC_irq,
  input  logic              coe_ARM,
  input  logic              coe_CLEAR,
  output logic [1:0]        coe_FAULT,
  output logic              coe_BUSY
);
  typedef enum logic [2:0] {IDLE, RD_STAT, WR_OFF, COOL, RESTORE, SETTLE, RD_VERIFY, FAULT} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic [1:0] oc_q, oc_d, loe_q, loe_d, hoe_q, hoe_d, pwr_q, pwr_d;
  logic [1:0] rd_oc;
  logic done;
  logic unused_rd;
  assign rd_oc = avm_M_readdata[1:0];
  assign done = ~avm_M_waitrequest;
  assign unused_rd = ^{avm_M_readdata[31:26], avm_M_readdata[23:18], avm_M_readdata[15:10], avm_M_readdata[7:2]};
  // Bus strobes decode straight from the state register so an async reset drops them at once
  assign avm_M_address = CTRL_ADDR;
  assign avm_M_byteenable = 4'hF;
  assign avm_M_read = state_q == RD_STAT || state_q == RD_VERIFY;
  assign avm_M_write = state_q == WR_OFF || state_q == RESTORE;
  assign avm_M_writedata = state_q == WR_OFF ? {6'b0, pwr_q & ~oc_q, 6'b0, hoe_q & ~oc_q, 6'b0, loe_q & ~oc_q, 8'b0} :
                           state_q == RESTORE ? {6'b0, pwr_q, 6'b0, hoe_q, 6'b0, loe_q, 8'b0} : 32'h0;
  assign coe_FAULT = state_q == FAULT ? oc_q : 2'b0;
  assign coe_BUSY = state_q != IDLE && state_q != FAULT;
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      retry_q <= '0;
      oc_q <= '0;
      loe_q <= '0;
      hoe_q <= '0;
      pwr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      oc_q <= oc_d;
      loe_q <= loe_d;
      hoe_q <= hoe_d;
      pwr_q <= pwr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    retry_d = retry_q;
    oc_d = oc_q;
    loe_d = loe_q;
    hoe_d = hoe_q;
    pwr_d = pwr_q;
    case (state_q)
      IDLE: state_d = coe_ARM && inr_OC_irq ? RD_STAT : IDLE;
      RD_STAT: if (done) begin
        oc_d = rd_oc;
        loe_d = avm_M_readdata[9:8];
        hoe_d = avm_M_readdata[17:16];
        pwr_d = avm_M_readdata[25:24];
        state_d = rd_oc == 2'b0 ? IDLE : WR_OFF;
      end
      WR_OFF: if (done) begin
        cnt_d = 32'(COOLDOWN_CYCLES - 1);
        state_d = COOL;
      end
      COOL: if (cnt_q == 32'h0) state_d = retry_q < 4'(RETRY_MAX) ? RESTORE : FAULT;
            else cnt_d = cnt_q - 32'h1;
      RESTORE: if (done) begin
        retry_d = retry_q + 4'h1;
        cnt_d = 32'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: if (cnt_q == 32'h0) state_d = RD_VERIFY;
              else cnt_d = cnt_q - 32'h1;
      // A newly faulted module is merged into oc; the retry budget keeps counting
      RD_VERIFY: if (done) begin
        if ((rd_oc & oc_q) == 2'b0) begin
          retry_d = '0;
          state_d = IDLE;
        end else begin
          oc_d = oc_q | rd_oc;
          state_d = WR_OFF;
        end
      end
      FAULT: if (coe_CLEAR) begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_qsys_shield_oc_guard_master.sv
// tb_qsys_shield_oc_guard_master: directed table, hand-written reset/stall sequences and
// randomized scenarios checked against a transaction-level model of the guard.
module tb_qsys_shield_oc_guard_master;
  localparam int COOL = 8, SETTLE = 4, RM = 2;
  localparam logic [31:0] ADDR = 32'h40;
  logic clk = 0, rst = 1;
  logic [31:0] addr, wdata, rdata;
  logic rd, wr, waitreq;
  logic [3:0] be;
  logic irq = 0, arm = 0, clr = 0;
  logic [1:0] fault;
  logic busy;

  qsys_shield_oc_guard_master #(.ADDR_W(32), .CTRL_ADDR(ADDR), .COOLDOWN_CYCLES(COOL),
    .SETTLE_CYCLES(SETTLE), .RETRY_MAX(RM)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .avm_M_address(addr), .avm_M_read(rd),
    .avm_M_write(wr), .avm_M_writedata(wdata), .avm_M_byteenable(be), .avm_M_readdata(rdata),
    .avm_M_waitrequest(waitreq), .inr_OC_irq(irq), .coe_ARM(arm), .coe_CLEAR(clr),
    .coe_FAULT(fault), .coe_BUSY(busy));

  always #5 clk = ~clk;

  // slave: programmable stall per transfer, reads served in order from rd_mem
  logic [31:0] rd_mem [256];
  logic [7:0] rd_idx = 0;
  int stall = 0;
  int ws = 0;
  assign waitreq = (rd || wr) && ws < stall;
  assign rdata = rd_mem[rd_idx];
  always @(posedge clk or posedge rst) begin
    if (rst) ws <= 0;
    else begin
      ws <= ((rd || wr) && ws < stall) ? ws + 1 : 0;
      if (rd && !waitreq) rd_idx <= rd_idx + 8'd1;
    end
  end

  // monitor: records completed transfers with first-assert and completion cycles
  typedef struct {logic wr; logic [31:0] data; logic [3:0] be; logic [31:0] addr; int st; int en;} xfer_t;
  xfer_t mon_q[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic in_x = 0, prd = 0, pwr = 0;
  logic [31:0] pdata = 0;
  int st_c = 0, unstable = 0, both = 0;
  always @(negedge clk) begin
    if (rst) in_x <= 0;
    else if (rd || wr) begin
      if (in_x && (rd !== prd || wr !== pwr || (wr && wdata !== pdata))) unstable <= unstable + 1;
      if (rd && wr) both <= both + 1;
      prd <= rd;
      pwr <= wr;
      pdata <= wdata;
      if (!waitreq) begin
        mon_q.push_back('{wr, wdata, be, addr, in_x ? st_c : cyc, cyc});
        in_x <= 0;
      end else begin
        in_x <= 1;
        if (!in_x) st_c <= cyc;
      end
    end else in_x <= 0;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // reference model: expected transfer list from the guard's rules (gap = cycles since previous completion)
  typedef struct {logic wr; logic [31:0] data; int gap;} exp_t;
  exp_t exp_q[$];
  task automatic model(input logic [31:0] r0, input logic [1:0] v0, input logic [1:0] v1, output logic [1:0] f);
    logic [31:0] keep;
    logic [1:0] oc, n;
    int tries, k;
    keep = r0 & 32'h03030300;
    oc = r0[1:0];
    tries = 0;
    k = 0;
    f = 0;
    exp_q.delete();
    exp_q.push_back('{1'b0, 32'h0, -1});
    if (oc == 0) return;
    forever begin
      exp_q.push_back('{1'b1, keep & ~{6'b0, oc, 6'b0, oc, 6'b0, oc, 8'b0}, 1});
      if (tries == RM) begin
        f = oc;
        return;
      end
      exp_q.push_back('{1'b1, keep, COOL + 1});
      tries++;
      exp_q.push_back('{1'b0, 32'h0, SETTLE + 1});
      n = k == 0 ? v0 : v1;
      k++;
      if ((n & oc) == 0) return;
      oc |= n;
    end
  endtask

  task automatic load_slave(input logic [31:0] r0, input logic [1:0] v0, input logic [1:0] v1);
    logic [31:0] keep;
    keep = r0 & 32'h03030300;
    rd_mem[rd_idx] = r0;
    rd_mem[rd_idx + 8'd1] = keep | 32'(v0);
    for (int k = 2; k < 16; k++) rd_mem[rd_idx + 8'(k)] = keep | 32'(v1);
  endtask

  task automatic pulse_irq(input logic arm_after);
    @(negedge clk);
    arm = 1;
    irq = 1;
    @(negedge clk);
    irq = 0;
    arm = arm_after;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1 && n < 50) begin @(negedge clk); n++; end
    while (busy !== 0 && n < 3000) begin @(negedge clk); n++; end
    chk({nm, " idle"}, 64'(busy), 0);
  endtask

  task automatic scenario(input string nm, input logic [31:0] r0, input logic [1:0] v0, input logic [1:0] v1,
                          input int st_in, input logic arm_after,
                          output int n, output logic [1:0] f, output logic [31:0] w0, output logic [31:0] wl);
    int base;
    logic [1:0] ef;
    logic got_w;
    stall = st_in;
    load_slave(r0, v0, v1);
    base = mon_q.size();
    model(r0, v0, v1, ef);
    pulse_irq(arm_after);
    wait_idle(nm);
    n = mon_q.size() - base;
    chk({nm, " count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk({nm, " kind"}, 64'(mon_q[base + i].wr), 64'(exp_q[i].wr));
      chk({nm, " addr"}, 64'(mon_q[base + i].addr), 64'(ADDR));
      if (exp_q[i].wr) begin
        chk({nm, " wdata"}, 64'(mon_q[base + i].data), 64'(exp_q[i].data));
        chk({nm, " be"}, 64'(mon_q[base + i].be), 64'hF);
      end
      if (exp_q[i].gap > 0) chk({nm, " gap"}, 64'(mon_q[base + i].st - mon_q[base + i - 1].en), 64'(exp_q[i].gap));
    end
    w0 = 0;
    wl = 0;
    got_w = 0;
    for (int i = 0; i < n; i++) if (mon_q[base + i].wr) begin
      if (!got_w) w0 = mon_q[base + i].data;
      got_w = 1;
      wl = mon_q[base + i].data;
    end
    f = fault;
    chk({nm, " fault"}, 64'(fault), 64'(ef));
    chk({nm, " stable"}, 64'(unstable), 0);
    chk({nm, " rd&wr"}, 64'(both), 0);
    if (ef != 0) begin
      repeat (20) @(negedge clk);
      chk({nm, " fault held"}, 64'(fault), 64'(ef));
      clr = 1;
      @(negedge clk);
      clr = 0;
      chk({nm, " cleared"}, 64'({fault, busy}), 0);
    end
  endtask

  typedef struct {logic [31:0] r0; logic [1:0] v0, v1; int stall; logic arm_after;
                  int n; logic [1:0] fault; logic [31:0] w0, wl;} vec_t;
  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w;
    logic [1:0] f, v0, v1;
    logic [31:0] w0, wl, r0;
    tbl[0] = '{32'h03030301, 2'd0, 2'd0, 0, 1'b1, 4, 2'd0, 32'h02020200, 32'h03030300};
    tbl[1] = '{32'h03030301, 2'd0, 2'd0, 3, 1'b1, 4, 2'd0, 32'h02020200, 32'h03030300};
    tbl[2] = '{32'h03030302, 2'd2, 2'd2, 0, 1'b1, 8, 2'd2, 32'h01010100, 32'h01010100};
    tbl[3] = '{32'h03030302, 2'd2, 2'd2, 2, 1'b0, 8, 2'd2, 32'h01010100, 32'h01010100};
    tbl[4] = '{32'h03030300, 2'd0, 2'd0, 0, 1'b1, 1, 2'd0, 32'h00000000, 32'h00000000};
    tbl[5] = '{32'h03030301, 2'd3, 2'd0, 1, 1'b1, 7, 2'd0, 32'h02020200, 32'h03030300};
    tbl[6] = '{32'h03030301, 2'd3, 2'd3, 0, 1'b1, 8, 2'd3, 32'h02020200, 32'h00000000};
    tbl[7] = '{32'h01000101, 2'd2, 2'd2, 1, 1'b0, 4, 2'd0, 32'h00000000, 32'h01000100};
    for (int i = 0; i < 256; i++) rd_mem[i] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    arm = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset quiet", 64'({rd, wr, busy, fault}), 0);
    end
    chk("reset wdata", 64'(wdata), 0);

    foreach (tbl[i]) begin
      scenario($sformatf("vec%0d", i), tbl[i].r0, tbl[i].v0, tbl[i].v1, tbl[i].stall, tbl[i].arm_after, n, f, w0, wl);
      chk($sformatf("vec%0d n", i), 64'(n), 64'(tbl[i].n));
      chk($sformatf("vec%0d f", i), 64'(f), 64'(tbl[i].fault));
      chk($sformatf("vec%0d w0", i), 64'(w0), 64'(tbl[i].w0));
      chk($sformatf("vec%0d wl", i), 64'(wl), 64'(tbl[i].wl));
    end

    // disarmed: irq alone must not start the bus
    w = mon_q.size();
    @(negedge clk);
    arm = 0;
    irq = 1;
    repeat (20) @(negedge clk);
    chk("disarmed busy", 64'({busy, rd, wr}), 0);
    irq = 0;
    chk("disarmed xfers", 64'(mon_q.size() - w), 0);

    // reset in COOL after one restore, then a full persistent run proves retry restarts at 0
    stall = 0;
    load_slave(32'h03030302, 2'd2, 2'd2);
    w = mon_q.size();
    pulse_irq(1'b1);
    n = 0;
    while (mon_q.size() - w < 5 && n < 500) begin @(negedge clk); n++; end
    chk("cool reached", 64'(mon_q.size() - w), 5);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 chk("rst cool", 64'({rd, wr, busy}), 0);
    @(negedge clk);
    rst = 0;
    scenario("post-rst", 32'h03030302, 2'd2, 2'd2, 0, 1'b1, n, f, w0, wl);
    chk("post-rst n", 64'(n), 8);

    // reset while a write is stalled drops the strobe immediately
    stall = 20;
    load_slave(32'h03030301, 2'd0, 2'd0);
    pulse_irq(1'b1);
    n = 0;
    while (wr !== 1 && n < 100) begin @(negedge clk); n++; end
    chk("stalled wr", 64'(wr), 1);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("rst wr drop", 64'({rd, wr, busy}), 0);
    @(negedge clk);
    rst = 0;
    stall = 0;
    @(negedge clk);
    chk("rst idle", 64'({busy, fault}), 0);

    for (int i = 0; i < 25; i++) begin
      r0 = $urandom & 32'h03030303;
      if ($urandom_range(0, 4) != 0 && r0[1:0] == 0) r0[0] = 1'b1;
      v0 = 2'($urandom_range(0, 3));
      v1 = 2'($urandom_range(0, 3));
      scenario($sformatf("rand%0d", i), r0, v0, v1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), n, f, w0, wl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
